lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store bus controller between the core's execute stage and data memory. It turns a core load or store request into a single handshaked bus access to memory that may insert wait states. It generates byte enables and lane-replicated store data, and shifts the returned read word so the addressed byte or halfword sits at bit 0. Its `rdata_aligned` output feeds the load sign/zero-extension stage directly. It stalls the core while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in BUSY waiting for `mem_ready` before aborting with a bus error; legal range 1–65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core presents a load/store this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3; bits [1:0] give size (00 = byte, 01 = half, 10 = word). Bit 2 is ignored here; extension is handled downstream.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `stall` out 1: core must hold its request and PC.
- `done` out 1: one-cycle pulse when the access completes.
- `misaligned` out 1: combinational fault flag; no bus access is made when it is set.
- `bus_err` out 1: valid with `done`; the access timed out.
- `rdata_aligned` out 32: shifted load data, valid with `done` on loads.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address, with `req_addr[1:0]` forced to 00.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory accepts the write or returns read data this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high.

## Operation
- The controller has three states: IDLE, BUSY and RESP.
- **IDLE:**
  - `misaligned` = `req_valid` & ((size == half & addr[0]) | (size == word & addr[1:0] != 0) | size == 11).
  - If `req_valid` & !`misaligned`: latch `mem_we`, `mem_addr`, `mem_be` and `mem_wdata`, set `mem_req` = 1, clear the timeout counter, and go to BUSY.
  - A misaligned request makes no bus access and does not stall; it produces no `done` pulse.
- **BUSY:**
  - `mem_req` and all bus outputs are held stable.
  - The counter increments each cycle.
  - On `mem_ready`: `mem_req` is set to 0. For a load, `rdata_aligned` is captured. Go to RESP with `bus_err` = 0.
  - When the counter reaches `TIMEOUT_CYCLES - 1` without `mem_ready`: `mem_req` is set to 0, `rdata_aligned` is set to 0, and the block goes to RESP with `bus_err` = 1.
  - If `mem_ready` arrives in the same cycle as the timeout, `mem_ready` wins.
- **RESP:** `done` = 1 and `stall` = 0, so the core retires the instruction at this edge. The next state is IDLE unconditionally; `req_valid` is ignored in RESP.
- `stall` = (IDLE & `req_valid` & !`misaligned`) | BUSY. It is combinational.
- **Byte enables:**
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 0}
  - word: 4'b1111
  - Enables are driven for loads as well as stores.
- **Store data:**
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **Read shift:**
  - byte: `mem_rdata` >> (8·addr[1:0])
  - half: >> (16·addr[1])
  - word: unshifted
  - Upper bits are passed as shifted, not masked; the downstream extension stage masks them.
- `rdata_aligned` holds its last load value across stores and idle cycles.
- **Reset:**
  - Reset forces IDLE on the next edge from any state, including mid-BUSY. `mem_req` drops and no `done` is issued.
  - Reset values are 0 for `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `rdata_aligned`, `done`, `bus_err` and the counter.

## Timing
- Minimum access takes 3 cycles: request seen in IDLE (cycle 0), BUSY with `mem_ready` (cycle 1), RESP/`done` (cycle 2).
- Each wait state adds 1 cycle.
- `mem_req` rises the cycle after the request is first seen. It stays high until the `mem_ready` cycle inclusive and falls on the following edge.
- `done` is high for exactly 1 cycle and never occurs in two consecutive cycles.
- The worst-case stall is `TIMEOUT_CYCLES` + 1 cycles.
- `misaligned` and `stall` are combinational from the `req_*` inputs. All other outputs are registered.

## Structure
- **Shared package `lsu_pkg`:**
  - state enum (IDLE/BUSY/RESP)
  - size encodings (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10)
  - `BE_ALL` = 4'b1111
  - `COUNT_W` = 16
- **Sub-module `lane_align`** (combinational): computes the byte enables, store replication and read shift from size and addr[1:0]. It is instantiated once.
- The FSM, counter and registers live in the top module.

## Test plan
- **Word store, addr 0x104, wdata 0xDEADBEEF, `mem_ready` in the first BUSY cycle:** `mem_addr` = 0x104, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF, `stall` high for 2 cycles, `done` on cycle 2.
- **Byte load, addr 0x203, `mem_rdata` = 0xA1B2C3D4:** `mem_be` = 1000, `rdata_aligned` = 0x000000A1 (bits [7:0] = 0xA1) with `done`.
- **Half store, addr 0x12, wdata 0x0000BEEF, 3 wait states:** `mem_be` = 1100, `mem_wdata` = 0xBEEFBEEF, `done` on cycle 5, bus outputs stable throughout BUSY.
- **Half load at addr 0x101:** `misaligned` = 1, `stall` = 0, `mem_req` never rises, no `done`.
- **Load with `mem_ready` held low, `TIMEOUT_CYCLES` = 4:**
  - `done` with `bus_err` = 1 and `rdata_aligned` = 0 after 4 BUSY cycles.
  - A repeat run asserts `mem_ready` on the last BUSY cycle and gets `bus_err` = 0.
- **Reset asserted in the second BUSY cycle:** `mem_req` = 0 on the next edge, FSM in IDLE, no `done`, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared state, size encodings and widths for the LSU bus controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam int         COUNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/lsu_bus_ctrl_lane_align.sv
// ---------------------------------------------------------------------------
// lane_align : byte enables, store lane replication and load right-shift
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = BE_ALL;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = rdata_i >> {off_i, 3'b000};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = rdata_i >> {off_i[1], 4'b0000};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl : single-access handshaked load/store bus controller with timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               done_q, done_d, bus_err_q, bus_err_d;
  logic [1:0]         size_q, size_d, off_q, off_d;

  logic [1:0]  req_size, la_size, la_off;
  logic [3:0]  la_be;
  logic [31:0] la_wdata, la_rdata;
  logic        accept;
  logic        unused_funct3;

  // Bit 2 selects sign/zero extension, which is applied downstream.
  assign unused_funct3 = req_funct3[2];
  assign req_size      = req_funct3[1:0];

  assign misaligned = req_valid &
                      (((req_size == SZ_HALF) & req_addr[0]) |
                       ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00)) |
                       (req_size == 2'b11));
  assign accept = (state_q == IDLE) & req_valid & ~misaligned;
  assign stall  = accept | (state_q == BUSY);

  // One aligner serves both phases: live request in IDLE, latched access after.
  assign la_size = (state_q == IDLE) ? req_size      : size_q;
  assign la_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;

  lane_align u_lane_align (
    .size_i  (la_size),
    .off_i   (la_off),
    .wdata_i (req_wdata),
    .rdata_i (mem_rdata),
    .be_o    (la_be),
    .wdata_o (la_wdata),
    .rdata_o (la_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    off_d       = off_q;
    done_d      = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = la_be;
          mem_wdata_d = la_wdata;
          size_d      = req_size;
          off_d       = req_addr[1:0];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) rdata_d = la_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rdata_d   = '0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign done          = done_q;
  assign bus_err       = bus_err_q;
  assign rdata_aligned = rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_ctrl : directed checks of lsu_bus_ctrl with TIMEOUT_CYCLES = 4
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] rdata_aligned;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .done          (done),
    .misaligned    (misaligned),
    .bus_err       (bus_err),
    .rdata_aligned (rdata_aligned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_be",      {28'd0, mem_be},  32'd0);
    chk("rst_rdata",   rdata_aligned,    32'd0);
    chk("rst_stall",   {31'd0, stall},   32'd0);

    // Word store, ready in first BUSY cycle
    request(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    chk("sw_stall_c0", {31'd0, stall}, 32'd1);
    chk("sw_mis",      {31'd0, misaligned}, 32'd0);
    tick();
    chk("sw_mem_req",  {31'd0, mem_req}, 32'd1);
    chk("sw_we",       {31'd0, mem_we},  32'd1);
    chk("sw_addr",     mem_addr,         32'h0000_0104);
    chk("sw_be",       {28'd0, mem_be},  32'h0000_000F);
    chk("sw_wdata",    mem_wdata,        32'hDEAD_BEEF);
    chk("sw_stall_c1", {31'd0, stall},   32'd1);
    chk("sw_done_c1",  {31'd0, done},    32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; #1;
    chk("sw_done_c2",  {31'd0, done},    32'd1);
    chk("sw_err",      {31'd0, bus_err}, 32'd0);
    chk("sw_stall_c2", {31'd0, stall},   32'd0);
    chk("sw_req_fall", {31'd0, mem_req}, 32'd0);
    tick();
    chk("sw_done_c3",  {31'd0, done},    32'd0);

    // Byte load (unsigned funct3) at offset 3
    request(1'b0, 3'b100, 32'h0000_0203, 32'hFFFF_FFFF);
    tick();
    chk("lb_be",   {28'd0, mem_be}, 32'h0000_0008);
    chk("lb_addr", mem_addr,        32'h0000_0200);
    chk("lb_we",   {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hA1B2_C3D4;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; #1;
    chk("lb_done",  {31'd0, done}, 32'd1);
    chk("lb_rdata", rdata_aligned, 32'h0000_00A1);
    tick();

    // Half store at 0x12 with 3 wait states
    request(1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF);
    tick();
    chk("sh_be",    {28'd0, mem_be}, 32'h0000_000C);
    chk("sh_wdata", mem_wdata,       32'hBEEF_BEEF);
    chk("sh_addr",  mem_addr,        32'h0000_0010);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("sh_wait_done",  {31'd0, done},    32'd0);
      chk("sh_wait_req",   {31'd0, mem_req}, 32'd1);
      chk("sh_wait_be",    {28'd0, mem_be},  32'h0000_000C);
      chk("sh_wait_wdata", mem_wdata,        32'hBEEF_BEEF);
      chk("sh_wait_stall", {31'd0, stall},   32'd1);
    end
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; #1;
    chk("sh_done_c5",   {31'd0, done}, 32'd1);
    chk("sh_rdata_hold", rdata_aligned, 32'h0000_00A1);
    tick();

    // Misaligned requests: no access, no stall, no done
    request(1'b0, 3'b001, 32'h0000_0101, 32'h0);
    chk("mis_half",  {31'd0, misaligned}, 32'd1);
    chk("mis_stall", {31'd0, stall},      32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mis_req",  {31'd0, mem_req}, 32'd0);
      chk("mis_done", {31'd0, done},    32'd0);
    end
    request(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk("mis_word", {31'd0, misaligned}, 32'd1);
    request(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    chk("mis_sz11", {31'd0, misaligned}, 32'd1);
    request(1'b0, 3'b001, 32'h0000_0102, 32'h0);
    chk("ok_half",  {31'd0, misaligned}, 32'd0);
    req_valid = 1'b0; #1;
    chk("mis_novalid", {31'd0, misaligned}, 32'd0);

    // Half load at offset 2
    request(1'b0, 3'b101, 32'h0000_0302, 32'h0);
    tick();
    chk("lh_be", {28'd0, mem_be}, 32'h0000_000C);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_1234;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; #1;
    chk("lh_rdata", rdata_aligned, 32'h0000_CAFE);
    tick();

    // Timeout with TIMEOUT_CYCLES = 4
    request(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_busy_req",  {31'd0, mem_req}, 32'd1);
      chk("to_busy_done", {31'd0, done},    32'd0);
    end
    tick();
    req_valid = 1'b0; #1;
    chk("to_done",  {31'd0, done},    32'd1);
    chk("to_err",   {31'd0, bus_err}, 32'd1);
    chk("to_rdata", rdata_aligned,    32'd0);
    chk("to_req",   {31'd0, mem_req}, 32'd0);
    tick();
    chk("to_done_pulse", {31'd0, done}, 32'd0);

    // Ready on the last BUSY cycle wins over timeout
    request(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    for (int c = 1; c <= 4; c++) tick();
    chk("tr_busy4_done", {31'd0, done}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_ready = 1'b0; req_valid = 1'b0; #1;
    chk("tr_done",  {31'd0, done},    32'd1);
    chk("tr_err",   {31'd0, bus_err}, 32'd0);
    chk("tr_rdata", rdata_aligned,    32'h1122_3344);
    tick();

    // Reset in second BUSY cycle
    request(1'b1, 3'b000, 32'h0000_0081, 32'h0000_0077);
    tick(); tick();
    chk("rb_busy2_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    tick();
    chk("rb_req",   {31'd0, mem_req}, 32'd0);
    chk("rb_done",  {31'd0, done},    32'd0);
    chk("rb_stall", {31'd0, stall},   32'd0);
    chk("rb_addr",  mem_addr,         32'd0);
    chk("rb_be",    {28'd0, mem_be},  32'd0);
    chk("rb_wdata", mem_wdata,        32'd0);
    chk("rb_we",    {31'd0, mem_we},  32'd0);
    chk("rb_rdata", rdata_aligned,    32'd0);
    chk("rb_err",   {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rb_done_after", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
